// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life step engine.
// Cell colours, grid defaults, neighbour order/offsets, FSM states.
package life_pkg;

  typedef enum logic [1:0] {
    DEAD  = 2'b00,
    RED   = 2'b01,
    GREEN = 2'b10,
    BLUE  = 2'b11
  } cell_t;

  localparam int GRID_W_DEF = 8;
  localparam int GRID_H_DEF = 8;

  localparam int NB_N = 9;

  localparam logic [3:0] NB_SELF = 4'd0;
  localparam logic [3:0] NB_NW   = 4'd1;
  localparam logic [3:0] NB_N_   = 4'd2;
  localparam logic [3:0] NB_NE   = 4'd3;
  localparam logic [3:0] NB_W    = 4'd4;
  localparam logic [3:0] NB_E    = 4'd5;
  localparam logic [3:0] NB_SW   = 4'd6;
  localparam logic [3:0] NB_S    = 4'd7;
  localparam logic [3:0] NB_SE   = 4'd8;

  // Offsets indexed by neighbour number; north is y-1.
  localparam int NB_DX [NB_N] =
    '{0, -1, 0, 1, -1, 1, -1, 0, 1};
  localparam int NB_DY [NB_N] =
    '{0, -1, -1, -1, 0, 0, 1, 1, 1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_FIN
  } state_t;

endpackage

// File: rtl/life_rule.sv
// Life rule for one cell: survival keeps colour, birth takes majority.
// Ports: self_i, live_i (0..8), r_i/g_i/b_i colour counts -> next_o.
module life_rule
  import life_pkg::*;
(
  input  cell_t      self_i,
  input  logic [3:0] live_i,
  input  logic [3:0] r_i,
  input  logic [3:0] g_i,
  input  logic [3:0] b_i,
  output cell_t      next_o
);

  always_comb begin
    next_o = DEAD;
    if (self_i != DEAD) begin
      if (live_i == 4'd2 || live_i == 4'd3)
        next_o = self_i;
    end else if (live_i == 4'd3) begin
      // Three parents: at most one colour can reach two.
      unique case (1'b1)
        (r_i >= 4'd2): next_o = RED;
        (g_i >= 4'd2): next_o = GREEN;
        (b_i >= 4'd2): next_o = BLUE;
        default:       next_o = RED;
      endcase
    end
  end

endmodule

// File: rtl/life_step_engine.sv
// One Game of Life generation over a torus, 11 cycles per cell.
// Ports: clk, rst_n, start, busy, done, rd_addr/rd_data (sync RAM),
// wr_en/wr_addr/wr_data (next-gen buffer), alive_count.
module life_step_engine
  import life_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int ADDR_W = $clog2(GRID_W * GRID_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data,
  output logic [ADDR_W:0]   alive_count
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(GRID_W * GRID_H - 1);

  state_t            state_q, state_d;
  logic [3:0]        k_q;
  logic [ADDR_W-1:0] cell_q;
  cell_t             self_q;
  logic [3:0]        live_q, r_q, g_q, b_q;
  logic [ADDR_W:0]   run_q, alive_q;

  cell_t             rd_cell;
  cell_t             next_c;
  logic              acc_en;
  logic [XW-1:0]     cx, nx;
  logic [YW-1:0]     cy, ny;

  assign rd_cell = cell_t'(rd_data);
  assign cx      = cell_q[XW-1:0];
  assign cy      = cell_q[ADDR_W-1:XW];

  // Power-of-two grid: truncating x-1 / x+1 gives the wrap.
  always_comb begin
    nx = XW'(int'(cx) + NB_DX[k_q]);
    ny = YW'(int'(cy) + NB_DY[k_q]);
  end

  // rd_data lags rd_addr by one cycle: READ k>=2 and DRAIN
  // see neighbours 1..8, READ k=1 sees SELF.
  assign acc_en = (state_q == S_READ && k_q >= 4'd2)
               || (state_q == S_DRAIN);

  life_rule u_rule (
    .self_i (self_q),
    .live_i (live_q),
    .r_i    (r_q),
    .g_i    (g_q),
    .b_i    (b_q),
    .next_o (next_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  if (k_q == 4'd8) state_d = S_DRAIN;
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: state_d = (cell_q == LAST) ? S_FIN : S_READ;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    wr_en   = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    unique case (state_q)
      S_READ: begin
        busy    = 1'b1;
        rd_addr = {ny, nx};
      end
      S_DRAIN: busy = 1'b1;
      S_WRITE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = cell_q;
        wr_data = next_c;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q     <= '0;
      cell_q  <= '0;
      self_q  <= DEAD;
      live_q  <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      run_q   <= '0;
      alive_q <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        cell_q <= '0;
        k_q    <= '0;
        run_q  <= '0;
      end
      if (state_q == S_READ) begin
        if (k_q != 4'd8) k_q <= k_q + 4'd1;
        if (k_q == 4'd0) begin
          live_q <= '0;
          r_q    <= '0;
          g_q    <= '0;
          b_q    <= '0;
        end
        if (k_q == 4'd1) self_q <= rd_cell;
      end
      if (acc_en) begin
        live_q <= live_q + {3'b0, rd_cell != DEAD};
        r_q    <= r_q + {3'b0, rd_cell == RED};
        g_q    <= g_q + {3'b0, rd_cell == GREEN};
        b_q    <= b_q + {3'b0, rd_cell == BLUE};
      end
      if (state_q == S_WRITE) begin
        if (next_c != DEAD) run_q <= run_q + 1'b1;
        if (cell_q != LAST) begin
          cell_q <= cell_q + 1'b1;
          k_q    <= '0;
        end
      end
      if (state_q == S_FIN) alive_q <= run_q;
    end
  end

  assign alive_count = alive_q;

endmodule

// File: doc/life_step_engine.md
Name: life_step_engine

Overview:
- Computes one Game of Life generation for the three-colour LED panel.
- Reads the current-generation cell buffer and writes the next generation into a separate buffer; top swaps the two buffers on done.
- Sits upstream of the frame buffer / WS2812 controller path. Triggered by the auto-update pulse.
- Torus topology: edges wrap in both axes.

Parameters:
- GRID_W, 8, cells per row (power of two).
- GRID_H, 8, rows (power of two).
- ADDR_W, $clog2(GRID_W*GRID_H), cell address width (derived; do not override).

Ports:
- clk  in  1  system clock (12 MHz)
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to compute a generation
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the next generation is fully written
- rd_addr  out  ADDR_W  current-gen read address
- rd_data  in  2  cell at rd_addr, valid exactly one cycle after rd_addr (sync RAM)
- wr_en  out  1  next-gen write strobe
- wr_addr  out  ADDR_W  next-gen write address
- wr_data  out  2  next-gen cell value
- alive_count  out  ADDR_W+1  live cells in last completed generation

Behaviour:
- Cell encoding: 00 dead, 01 red, 10 green, 11 blue. Any non-zero value is alive.
- Address mapping: addr = y*GRID_W + x. Wrap: x-1 at x=0 gives GRID_W-1; x+1 at GRID_W-1 gives 0. Same rule for y.
- Reset (rst_n low at a clk edge): state IDLE; busy, done, wr_en = 0; rd_addr, wr_addr, wr_data = 0; alive_count = 0.
- Reset mid-pass aborts the pass immediately. No further writes. done is not pulsed.
- FSM: IDLE -> READ -> DRAIN -> WRITE -> (READ for next cell | FIN) -> IDLE.
- IDLE: on start=1, go to READ for cell 0, clear running live counter, busy=1 from the next cycle.
- READ: 9 cycles, k=0..8. Cycle k drives rd_addr = neighbour k in the fixed order SELF, NW, N, NE, W, E, SW, S, SE. rd_data for k-1 is captured in cycle k.
- DRAIN: 1 cycle; captures neighbour 8.
- Accumulators: live-neighbour count (0..8, 4 bits) and per-colour counts over the 8 neighbours, excluding SELF.
- WRITE: 1 cycle. wr_en=1, wr_addr = cell, wr_data = rule result. Running live counter increments if the result is non-zero.
- Rule:
  - alive with 2 or 3 neighbours: keeps its own colour.
  - dead with exactly 3 neighbours: born with the colour held by ≥2 of them; if all three colours differ, born 01.
  - otherwise: 00.
- Timing: 11 cycles per cell. Last cell: WRITE -> FIN.
- FIN: done=1 for one cycle, alive_count latched, busy=0 in the same cycle, return to IDLE.
- Start accepted at edge E0 gives done high in cycle E0 + 704 + 1 (64×11 + FIN) for the default grid.
- wr_en is 0 in every state except WRITE.
- start while busy or in FIN is ignored, not queued.
- start in the same cycle as rst_n=0: reset wins.
- alive_count holds its value between passes and is updated only in FIN.

Decomposition:
- Package life_pkg:
  - cell_t enum (DEAD, RED, GREEN, BLUE)
  - GRID_W/GRID_H defaults
  - neighbour index constants, in the order SELF..SE, with dx/dy offset tables
  - FSM state enum
- Sub-module life_rule: combinational. Inputs: self cell_t, live count, three colour counts. Output: next cell_t. Unit-testable on its own.

Test Plan:
- Blinker: cells (3,2),(3,3),(3,4) = 01, all else dead, start -> writes (2,3),(3,3),(4,3) = 01, all else 00; alive_count=3; done exactly 705 cycles after start.
- Block 2×2 green at (0,0)-(1,1) -> identical output; alive_count=4. Every address 0..63 written exactly once, in ascending order.
- Wrap: red cells at (7,0),(0,0),(1,0) -> (0,7),(0,0),(0,1) alive red. Proves wrap in both axes.
- Birth colour:
  - parents R,R,B around a dead cell -> born 01.
  - parents R,G,B -> born 01.
  - parents G,B,B -> born 11.
- Survivor keeps colour: blue cell with 2 live red neighbours -> stays 11.
- start pulsed again at cycle 100 of a pass -> ignored, single done. rst_n low at cycle 300 -> wr_en 0 next cycle, busy 0, no done, alive_count 0. A later start completes normally.
